fpu_issue_queue: RTL and testbench



---
 rtl/fpu_pkg.sv | 11 +
 rtl/fpu_issue_fifo.sv | 50 +++++
 rtl/fpu_issue_queue.sv | 61 ++++++
 tb/tb_fpu_issue_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Types and constants shared by the FPU front end.
package fpu_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] intval;
  } fpu_entry_t;

endpackage

// File: rtl/fpu_issue_fifo.sv
// Generic pointer-based FIFO with a synchronous flush. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module fpu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; empty masks stale contents, and leaving the
  // array out of the reset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/fpu_issue_queue.sv
// Issue queue in front of the FPU: buffers {inst, intval}, presents the head,
// stalls on hazard, and returns the integer operand one cycle after issue.
module fpu_issue_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = fpu_pkg::NOP_INST
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [31:0]              in_intval,
  output logic [31:0]              fpu_inst,
  output logic                     fpu_is_legl,
  input  logic                     fpu_hazard,
  output logic [31:0]              fpu_intval,
  output logic [$clog2(DEPTH):0]   count
);

  import fpu_pkg::*;

  fpu_entry_t wr_entry;
  fpu_entry_t head;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  assign in_ready = ~full & ~flush;
  assign push     = in_valid & in_ready;
  assign wr_entry = '{inst: in_inst, intval: in_intval};

  fpu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fpu_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // fpu_inst is built from registered state only, so the hazard path that
  // closes through the FPU and back into fpu_is_legl cannot form a loop.
  assign fpu_inst    = empty ? NOP_INST : head.inst;
  assign fpu_is_legl = ~empty & ~fpu_hazard & ~flush;
  assign pop         = fpu_is_legl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            fpu_intval <= '0;
    else if (fpu_is_legl) fpu_intval <= head.intval;
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed self-checking bench for fpu_issue_queue (DEPTH = 4).
module tb_fpu_issue_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_intval = '0;
  logic [31:0] fpu_inst;
  logic        fpu_is_legl;
  logic        fpu_hazard = 1'b0;
  logic [31:0] fpu_intval;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fpu_issue_queue #(.DEPTH(4), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_intval   (in_intval),
    .fpu_inst    (fpu_inst),
    .fpu_is_legl (fpu_is_legl),
    .fpu_hazard  (fpu_hazard),
    .fpu_intval  (fpu_intval),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled in the middle of the high phase.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] iv);
    in_valid  = v;
    in_inst   = inst;
    in_intval = iv;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] full_inst [5];
  logic [31:0] full_iv   [5];

  initial begin
    for (int i = 0; i < 5; i++) begin
      full_inst[i] = 32'h1000_0053 + 32'(i) * 32'h100;
      full_iv[i]   = 32'hC0DE_0000 + 32'(i);
    end

    // Reset and idle
    #13 rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_ready", in_ready, 1);
      check("idle_count", count, 0);
      check("idle_inst", fpu_inst, NOP);
      check("idle_legl", fpu_is_legl, 0);
    end
    check("idle_intval", fpu_intval, 0);

    // Single issue
    drive(1, 32'h00A5F053, 32'h0000002A); settle();
    check("single_ready", in_ready, 1);
    check("single_empty_legl", fpu_is_legl, 0);
    cyc(); drive(0, 0, 0); settle();
    check("single_inst", fpu_inst, 32'h00A5F053);
    check("single_legl", fpu_is_legl, 1);
    check("single_count1", count, 1);
    cyc(); settle();
    check("single_intval", fpu_intval, 32'h0000002A);
    check("single_count0", count, 0);
    check("single_after_legl", fpu_is_legl, 0);
    check("single_after_inst", fpu_inst, NOP);

    // Hazard stall: A then B, A held for three hazard cycles
    cyc(); drive(1, 32'hAAAA_0053, 32'h0000_00A1); settle();
    cyc(); drive(1, 32'hBBBB_0053, 32'h0000_00B2); fpu_hazard = 1; settle();
    check("haz1_inst", fpu_inst, 32'hAAAA_0053);
    check("haz1_legl", fpu_is_legl, 0);
    cyc(); drive(0, 0, 0); settle();
    check("haz2_inst", fpu_inst, 32'hAAAA_0053);
    check("haz2_legl", fpu_is_legl, 0);
    check("haz2_count", count, 2);
    cyc(); settle();
    check("haz3_inst", fpu_inst, 32'hAAAA_0053);
    check("haz3_legl", fpu_is_legl, 0);
    check("haz3_intval", fpu_intval, 32'h0000002A);
    cyc(); fpu_hazard = 0; settle();
    check("hazA_inst", fpu_inst, 32'hAAAA_0053);
    check("hazA_legl", fpu_is_legl, 1);
    cyc(); settle();
    check("hazB_inst", fpu_inst, 32'hBBBB_0053);
    check("hazB_legl", fpu_is_legl, 1);
    check("hazA_intval", fpu_intval, 32'h0000_00A1);
    cyc(); settle();
    check("hazB_intval", fpu_intval, 32'h0000_00B2);
    check("haz_count", count, 0);
    check("haz_done_legl", fpu_is_legl, 0);

    // Full: four pushes under hazard, fifth held upstream
    fpu_hazard = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, full_inst[i], full_iv[i]); settle();
      check($sformatf("fill%0d_ready", i), in_ready, 1);
    end
    cyc(); drive(1, full_inst[4], full_iv[4]); settle();
    check("full_ready", in_ready, 0);
    check("full_count", count, 4);
    check("full_legl", fpu_is_legl, 0);
    cyc(); fpu_hazard = 0; settle();
    check("full_still", in_ready, 0);
    check("drain0_inst", fpu_inst, full_inst[0]);
    check("drain0_legl", fpu_is_legl, 1);
    cyc(); settle();
    check("fifth_ready", in_ready, 1);
    check("drain1_inst", fpu_inst, full_inst[1]);
    check("drain1_legl", fpu_is_legl, 1);
    check("drain0_intval", fpu_intval, full_iv[0]);
    check("drain1_count", count, 3);
    cyc(); drive(0, 0, 0); settle();
    check("pushpop_count", count, 3);
    check("drain2_inst", fpu_inst, full_inst[2]);
    check("drain2_legl", fpu_is_legl, 1);
    cyc(); settle();
    check("drain3_inst", fpu_inst, full_inst[3]);
    check("drain3_count", count, 2);
    cyc(); settle();
    check("drain4_inst", fpu_inst, full_inst[4]);
    check("drain4_legl", fpu_is_legl, 1);
    check("drain3_intval", fpu_intval, full_iv[3]);
    cyc(); settle();
    check("drain_count", count, 0);
    check("drain4_intval", fpu_intval, full_iv[4]);

    // Flush while three entries are held
    fpu_hazard = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1, 32'hF000_0053 + 32'(i), 32'h5555_0000 + 32'(i)); settle();
    end
    cyc(); drive(1, 32'hDEAD_0053, 32'h1234_5678); fpu_hazard = 0; flush = 1; settle();
    check("flush_count_before", count, 3);
    check("flush_legl", fpu_is_legl, 0);
    check("flush_ready", in_ready, 0);
    cyc(); drive(0, 0, 0); flush = 0; settle();
    check("flush_count", count, 0);
    check("flush_inst", fpu_inst, NOP);
    check("flush_intval", fpu_intval, full_iv[4]);
    check("flush_after_legl", fpu_is_legl, 0);

    // Asynchronous reset between edges
    fpu_hazard = 1;
    cyc(); drive(1, 32'h7777_0053, 32'h0000_0077); settle();
    cyc(); drive(1, 32'h8888_0053, 32'h0000_0088); settle();
    cyc(); drive(0, 0, 0); settle();
    check("prereset_count", count, 2);
    #2 rstn = 1'b0;
    #1;
    check("areset_count", count, 0);
    check("areset_inst", fpu_inst, NOP);
    check("areset_intval", fpu_intval, 0);
    check("areset_ready", in_ready, 1);
    fpu_hazard = 0;
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("postreset_legl", fpu_is_legl, 0);
      check("postreset_count", count, 0);
    end
    drive(1, 32'h9999_0053, 32'h0000_0099); settle();
    cyc(); drive(0, 0, 0); settle();
    check("postreset_inst", fpu_inst, 32'h9999_0053);
    check("postreset_issue", fpu_is_legl, 1);
    cyc(); settle();
    check("postreset_intval", fpu_intval, 32'h0000_0099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish by 20000");
    $fatal(1, "timeout");
  end

endmodule
